// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator for the decode stage.
// The incoming instruction is decoded combinationally. The result moves through a
// two-entry valid/ready skid buffer: the output register OR, backed by the skid
// register SK. Accepted unsupported opcodes are counted in a saturating counter.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter bit SUPPORT_UJ = 1'b1,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count,
  input  logic             err_clr
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;

  logic             or_valid_q, or_valid_d;
  logic [XLEN-1:0]  or_imm_q, or_imm_d;
  logic [2:0]       or_fmt_q, or_fmt_d;
  logic             or_ill_q, or_ill_d;
  logic             sk_valid_q, sk_valid_d;
  logic [XLEN-1:0]  sk_imm_q, sk_imm_d;
  logic [2:0]       sk_fmt_q, sk_fmt_d;
  logic             sk_ill_q, sk_ill_d;
  logic             in_ready_q, in_ready_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             accept;
  logic             drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = or_valid_q && out_ready;

  // Decode the opcode, build the 32-bit immediate, then sign-extend it to XLEN
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0100011: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        if (SUPPORT_UJ) begin
          imm32   = {instr[31:12], 12'b0};
          dec_fmt = FMT_U;
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b1101111: begin
        if (SUPPORT_UJ) begin
          imm32   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
          dec_fmt = FMT_J;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  // Skid-buffer next state: SK refills OR on drain, else new data goes to the first free slot
  always_comb begin
    or_valid_d = or_valid_q;
    or_imm_d   = or_imm_q;
    or_fmt_d   = or_fmt_q;
    or_ill_d   = or_ill_q;
    sk_valid_d = sk_valid_q;
    sk_imm_d   = sk_imm_q;
    sk_fmt_d   = sk_fmt_q;
    sk_ill_d   = sk_ill_q;
    if (drain) begin
      if (sk_valid_q) begin
        or_imm_d   = sk_imm_q;
        or_fmt_d   = sk_fmt_q;
        or_ill_d   = sk_ill_q;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        or_imm_d   = dec_imm;
        or_fmt_d   = dec_fmt;
        or_ill_d   = dec_ill;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!or_valid_q) begin
        or_valid_d = 1'b1;
        or_imm_d   = dec_imm;
        or_fmt_d   = dec_fmt;
        or_ill_d   = dec_ill;
      end else begin
        sk_valid_d = 1'b1;
        sk_imm_d   = dec_imm;
        sk_fmt_d   = dec_fmt;
        sk_ill_d   = dec_ill;
      end
    end
    in_ready_d = !sk_valid_d;
  end

  // Illegal-opcode counter: clear has priority, increments stop at the maximum
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (accept && dec_ill && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // State registers; reset empties both entries and holds in_ready low
  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid_q  <= 1'b0;
      or_imm_q    <= '0;
      or_fmt_q    <= '0;
      or_ill_q    <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_imm_q    <= '0;
      sk_fmt_q    <= '0;
      sk_ill_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      or_valid_q  <= or_valid_d;
      or_imm_q    <= or_imm_d;
      or_fmt_q    <= or_fmt_d;
      or_ill_q    <= or_ill_d;
      sk_valid_q  <= sk_valid_d;
      sk_imm_q    <= sk_imm_d;
      sk_fmt_q    <= sk_fmt_d;
      sk_ill_q    <= sk_ill_d;
      in_ready_q  <= in_ready_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign imm       = or_imm_q;
  assign fmt       = or_fmt_q;
  assign illegal   = or_ill_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe.
// Four instances share one stimulus stream: the default build, XLEN=64,
// SUPPORT_UJ=0 and ERR_W=2, so parameter variants see identical traffic.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready, out_valid, illegal;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [15:0] err_count;

  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [15:0] err_count64;

  logic        in_ready_nu, out_valid_nu, illegal_nu;
  logic [31:0] imm_nu;
  logic [2:0]  fmt_nu;
  logic [15:0] err_count_nu;

  logic        in_ready_e2, out_valid_e2, illegal_e2;
  logic [31:0] imm_e2;
  logic [2:0]  fmt_e2;
  logic [1:0]  err_count_e2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SUPPORT_UJ(1'b1), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .imm(imm),
    .fmt(fmt), .illegal(illegal), .err_count(err_count), .err_clr(err_clr)
  );

  imm_gen_pipe #(.XLEN(64), .SUPPORT_UJ(1'b1), .ERR_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
    .fmt(fmt64), .illegal(illegal64), .err_count(err_count64), .err_clr(err_clr)
  );

  imm_gen_pipe #(.XLEN(32), .SUPPORT_UJ(1'b0), .ERR_W(16)) dut_nu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nu),
    .instr(instr), .out_valid(out_valid_nu), .out_ready(out_ready), .imm(imm_nu),
    .fmt(fmt_nu), .illegal(illegal_nu), .err_count(err_count_nu), .err_clr(err_clr)
  );

  imm_gen_pipe #(.XLEN(32), .SUPPORT_UJ(1'b1), .ERR_W(2)) dut_e2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_e2),
    .instr(instr), .out_valid(out_valid_e2), .out_ready(out_ready), .imm(imm_e2),
    .fmt(fmt_e2), .illegal(illegal_e2), .err_count(err_count_e2), .err_clr(err_clr)
  );

  // Advance to just after the next rising edge, where outputs are sampled and inputs change
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values of every output, then in_ready rising on the first cycle out of reset
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; instr = 32'h0; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, imm, fmt, illegal, err_count, in_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ov=%0b imm=%h fmt=%0d ill=%0b cnt=%0d rdy=%0b, want all 0",
               out_valid, imm, fmt, illegal, err_count, in_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %0b want 1", in_ready);
    end
  endtask

  // One instruction per format through an idle pipe, checked on all width/UJ variants
  task automatic test_formats();
    logic [31:0] vec_instr [8];
    logic [31:0] vec_imm   [8];
    logic [2:0]  vec_fmt   [8];
    logic [63:0] exp64;
    logic [31:0] exp_nu_imm;
    logic [2:0]  exp_nu_fmt;
    logic        exp_nu_ill;
    vec_instr[0] = 32'hFFF17093; vec_imm[0] = 32'hFFFFFFFF; vec_fmt[0] = 3'd1; // ANDI
    vec_instr[1] = 32'hFE531E23; vec_imm[1] = 32'hFFFFFFFC; vec_fmt[1] = 3'd2; // SH
    vec_instr[2] = 32'hFE009CE3; vec_imm[2] = 32'hFFFFFFF8; vec_fmt[2] = 3'd3; // BNE
    vec_instr[3] = 32'h123450B7; vec_imm[3] = 32'h12345000; vec_fmt[3] = 3'd4; // LUI
    vec_instr[4] = 32'h00001097; vec_imm[4] = 32'h00001000; vec_fmt[4] = 3'd4; // AUIPC
    vec_instr[5] = 32'h0080006F; vec_imm[5] = 32'h00000008; vec_fmt[5] = 3'd5; // JAL +8
    vec_instr[6] = 32'hFFDFF0EF; vec_imm[6] = 32'hFFFFFFFC; vec_fmt[6] = 3'd5; // JAL -4
    vec_instr[7] = 32'h00812083; vec_imm[7] = 32'h00000008; vec_fmt[7] = 3'd1; // LW
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      instr    = vec_instr[i];
      tick();
      in_valid = 1'b0;
      exp64 = {{32{vec_imm[i][31]}}, vec_imm[i]};
      exp_nu_ill = (vec_fmt[i] == 3'd4) || (vec_fmt[i] == 3'd5);
      exp_nu_imm = exp_nu_ill ? 32'h0 : vec_imm[i];
      exp_nu_fmt = exp_nu_ill ? 3'd0 : vec_fmt[i];
      checks++;
      if ({out_valid, imm, fmt, illegal} !== {1'b1, vec_imm[i], vec_fmt[i], 1'b0}) begin
        errors++;
        $display("[TB] FAIL fmt32_%0d: got ov=%0b imm=%h fmt=%0d ill=%0b want ov=1 imm=%h fmt=%0d ill=0",
                 i, out_valid, imm, fmt, illegal, vec_imm[i], vec_fmt[i]);
      end
      checks++;
      if ({out_valid64, imm64, fmt64, illegal64} !== {1'b1, exp64, vec_fmt[i], 1'b0}) begin
        errors++;
        $display("[TB] FAIL fmt64_%0d: got ov=%0b imm=%h fmt=%0d ill=%0b want ov=1 imm=%h fmt=%0d ill=0",
                 i, out_valid64, imm64, fmt64, illegal64, exp64, vec_fmt[i]);
      end
      checks++;
      if ({out_valid_nu, imm_nu, fmt_nu, illegal_nu} !== {1'b1, exp_nu_imm, exp_nu_fmt, exp_nu_ill}) begin
        errors++;
        $display("[TB] FAIL fmt_nouj_%0d: got ov=%0b imm=%h fmt=%0d ill=%0b want ov=1 imm=%h fmt=%0d ill=%0b",
                 i, out_valid_nu, imm_nu, fmt_nu, illegal_nu, exp_nu_imm, exp_nu_fmt, exp_nu_ill);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fmt_drain_%0d: got out_valid=%0b want 0", i, out_valid);
      end
    end
  endtask

  // Stream A,B,C into a stalled consumer, then release it and check order and readiness
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00100093;
    tick();
    instr = 32'h00200093;
    tick();
    checks++;
    if ({out_valid, imm, in_ready} !== {1'b1, 32'h1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL bp_full: got ov=%0b imm=%h rdy=%0b want ov=1 imm=1 rdy=0", out_valid, imm, in_ready);
    end
    instr = 32'h00300093;
    tick();
    checks++;
    if ({out_valid, imm, in_ready} !== {1'b1, 32'h1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL bp_hold: got ov=%0b imm=%h rdy=%0b want ov=1 imm=1 rdy=0", out_valid, imm, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, imm, in_ready} !== {1'b1, 32'h2, 1'b1}) begin
      errors++;
      $display("[TB] FAIL bp_second: got ov=%0b imm=%h rdy=%0b want ov=1 imm=2 rdy=1", out_valid, imm, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, imm} !== {1'b1, 32'h3}) begin
      errors++;
      $display("[TB] FAIL bp_third: got ov=%0b imm=%h want ov=1 imm=3", out_valid, imm);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_empty: got out_valid=%0b want 0", out_valid);
    end
  endtask

  // Full throughput: one new instruction per cycle with out_ready held high
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      instr    = {12'(i * 16), 20'h00093};
      tick();
      checks++;
      if ({out_valid, imm, in_ready} !== {1'b1, 32'(i * 16), 1'b1}) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got ov=%0b imm=%h rdy=%0b want ov=1 imm=%h rdy=1",
                 i, out_valid, imm, in_ready, 32'(i * 16));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  // Illegal opcodes: flags, counting, clear priority and saturation of a narrow counter
  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      instr    = 32'hFFFFFFFF;
      tick();
      checks++;
      if ({out_valid, imm, fmt, illegal} !== {1'b1, 32'h0, 3'd0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL illegal_flag_%0d: got ov=%0b imm=%h fmt=%0d ill=%0b want ov=1 imm=0 fmt=0 ill=1",
                 i, out_valid, imm, fmt, illegal);
      end
    end
    checks++;
    if (err_count !== 16'd3) begin
      errors++;
      $display("[TB] FAIL err_count_three: got %0d want 3", err_count);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if ({err_count, err_count_e2} !== {16'd0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL err_clr_wins: got %0d/%0d want 0/0", err_count, err_count_e2);
    end
    for (int i = 0; i < 5; i++) begin
      instr = 32'h0000007F;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({err_count, err_count_e2} !== {16'd5, 2'd3}) begin
      errors++;
      $display("[TB] FAIL err_saturate: got %0d/%0d want 5/3", err_count, err_count_e2);
    end
    tick();
  endtask

  // Reset with both entries occupied drops them and the counter
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00100093;
    tick();
    instr = 32'h00200093;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== {1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_prefill: got ov=%0b rdy=%0b want ov=1 rdy=0", out_valid, in_ready);
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, imm, err_count, in_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got ov=%0b imm=%h cnt=%0d rdy=%0b want all 0",
               out_valid, imm, err_count, in_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid} !== {1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_release: got rdy=%0b ov=%0b want rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
